// File: rtl/pwm_reg_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_reg_pkg
// Description : Shared types and constants for the PWM register-bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] c_DEF_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          c_DEF_TIMEOUT  = 15;

    // Global register indices, as seen on reg_addr.
    localparam int unsigned GLBL_CTRL      = 0;
    localparam int unsigned GLBL_RSVD      = 1;
    localparam int unsigned GLBL_INTR_MSK  = 2;
    localparam int unsigned GLBL_INTR_STAT = 3;

endpackage
`default_nettype wire

// File: rtl/pwm_reg_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_wbd_if / pwm_reg_if
// Description : Wishbone-classic slave bus and PWM register bus bundles.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_wbd_if #(
    parameter int AW = 2
) ();
    logic          wbd_cyc_i;
    logic          wbd_stb_i;
    logic          wbd_we_i;
    logic [AW+1:0] wbd_adr_i;
    logic [31:0]   wbd_dat_i;
    logic [3:0]    wbd_sel_i;
    logic [31:0]   wbd_dat_o;
    logic          wbd_ack_o;
    logic          wbd_err_o;

    modport master (
        output wbd_cyc_i, wbd_stb_i, wbd_we_i, wbd_adr_i, wbd_dat_i, wbd_sel_i,
        input  wbd_dat_o, wbd_ack_o, wbd_err_o
    );

    modport slave (
        input  wbd_cyc_i, wbd_stb_i, wbd_we_i, wbd_adr_i, wbd_dat_i, wbd_sel_i,
        output wbd_dat_o, wbd_ack_o, wbd_err_o
    );
endinterface

interface pwm_reg_if #(
    parameter int AW = 2
) ();
    logic          reg_cs;
    logic          reg_wr;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_wdata;
    logic [3:0]    reg_be;
    logic [31:0]   reg_rdata;
    logic          reg_ack;

    modport master (
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack
    );
endinterface
`default_nettype wire

// File: rtl/pwm_reg_initiator.sv
`default_nettype none
// ============================================================================
// Module      : pwm_reg_initiator
// Description : Wishbone-classic slave to PWM register-bus initiator with
//               per-access timeout. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_reg_initiator
    import pwm_reg_pkg::*;
#(
    parameter int          AW       = 2,
    parameter int          TO_W     = 4,
    parameter int          TIMEOUT  = c_DEF_TIMEOUT,
    parameter logic [31:0] ERR_DATA = c_DEF_ERR_DATA
) (
    input  logic       mclk,
    input  logic       h_reset_n,
    pwm_wbd_if.slave   wbd,
    pwm_reg_if.master  regb,
    output logic       timeout_flag
);

    localparam logic [TO_W-1:0] c_CNT_LAST = TO_W'(TIMEOUT - 1);

    state_t          r_state, w_state_nx;
    logic [TO_W-1:0] r_cnt, w_cnt_nx;
    logic            r_abort, w_abort_nx, w_abort;
    logic            r_cs, w_cs_nx;
    logic            r_wr, w_wr_nx;
    logic [AW-1:0]   r_addr, w_addr_nx;
    logic [31:0]     r_wdata, w_wdata_nx;
    logic [3:0]      r_be, w_be_nx;
    logic [31:0]     r_dat, w_dat_nx;
    logic            r_ack, w_ack_nx;
    logic            r_err, w_err_nx;
    logic            r_flag, w_flag_nx;
    logic            w_unused_adr;

    // Byte-lane bits of the wishbone address carry no information here.
    assign w_unused_adr = ^wbd.wbd_adr_i[1:0];

    // Abort latches once the master drops cyc mid-access; the reg-bus
    // transfer still runs to completion so no register is half-written.
    assign w_abort = r_abort | ~wbd.wbd_cyc_i;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_abort_nx = r_abort;
        w_cs_nx    = r_cs;
        w_wr_nx    = r_wr;
        w_addr_nx  = r_addr;
        w_wdata_nx = r_wdata;
        w_be_nx    = r_be;
        w_dat_nx   = r_dat;
        w_ack_nx   = 1'b0;
        w_err_nx   = 1'b0;
        w_flag_nx  = r_flag;

        case (r_state)
            IDLE: begin
                if (wbd.wbd_cyc_i && wbd.wbd_stb_i) begin
                    w_wr_nx    = wbd.wbd_we_i;
                    w_addr_nx  = wbd.wbd_adr_i[AW+1:2];
                    w_wdata_nx = wbd.wbd_dat_i;
                    w_be_nx    = wbd.wbd_sel_i;
                    w_cs_nx    = 1'b1;
                    w_cnt_nx   = '0;
                    w_abort_nx = 1'b0;
                    w_state_nx = ACCESS;
                end
            end
            ACCESS: begin
                w_cnt_nx   = r_cnt + 1'b1;
                w_abort_nx = w_abort;
                if (regb.reg_ack) begin
                    w_cs_nx    = 1'b0;
                    w_ack_nx   = ~w_abort;
                    w_flag_nx  = 1'b0;
                    w_state_nx = RESP;
                    if (!r_wr) begin
                        w_dat_nx = regb.reg_rdata;
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    w_cs_nx    = 1'b0;
                    w_err_nx   = ~w_abort;
                    w_flag_nx  = 1'b1;
                    w_state_nx = RESP;
                    if (!r_wr) begin
                        w_dat_nx = ERR_DATA;
                    end
                end
            end
            RESP: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
                w_cs_nx    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_cs    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_abort <= w_abort_nx;
            r_cs    <= w_cs_nx;
            r_wr    <= w_wr_nx;
            r_addr  <= w_addr_nx;
            r_wdata <= w_wdata_nx;
            r_be    <= w_be_nx;
            r_dat   <= w_dat_nx;
            r_ack   <= w_ack_nx;
            r_err   <= w_err_nx;
            r_flag  <= w_flag_nx;
        end
    end

    assign regb.reg_cs    = r_cs;
    assign regb.reg_wr    = r_wr;
    assign regb.reg_addr  = r_addr;
    assign regb.reg_wdata = r_wdata;
    assign regb.reg_be    = r_be;
    assign wbd.wbd_dat_o  = r_dat;
    assign wbd.wbd_ack_o  = r_ack;
    assign wbd.wbd_err_o  = r_err;
    assign timeout_flag   = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_pwm_reg_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_reg_initiator
// Description : Directed self-checking bench with a delay-programmable slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_reg_initiator;
    import pwm_reg_pkg::*;

    localparam logic [31:0] c_MASK = 32'h0000_FFFF;

    logic mclk = 1'b0;
    logic h_reset_n = 1'b0;
    logic timeout_flag;

    int checks = 0;
    int errors = 0;

    // Slave model: acks after slv_delay cycles of cs (0 = never acks).
    int          slv_delay = 1;
    int          slv_age   = 0;
    int          slv_acks  = 0;
    logic [31:0] mem [4]   = '{default: 32'h0};

    pwm_wbd_if #(.AW(2)) wbd ();
    pwm_reg_if #(.AW(2)) regb ();

    pwm_reg_initiator dut (
        .mclk         (mclk),
        .h_reset_n    (h_reset_n),
        .wbd          (wbd),
        .regb         (regb),
        .timeout_flag (timeout_flag)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            regb.reg_ack   <= 1'b0;
            regb.reg_rdata <= 32'h0;
            slv_age        <= 0;
        end else if (regb.reg_cs && !regb.reg_ack) begin
            slv_age <= slv_age + 1;
            if (slv_delay != 0 && slv_age + 1 == slv_delay) begin
                regb.reg_ack   <= 1'b1;
                slv_acks       <= slv_acks + 1;
                regb.reg_rdata <= mem[regb.reg_addr] & c_MASK;
                if (regb.reg_wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (regb.reg_be[b])
                            mem[regb.reg_addr][b*8 +: 8] <= regb.reg_wdata[b*8 +: 8] & c_MASK[b*8 +: 8];
                    end
                end
            end
        end else begin
            regb.reg_ack <= 1'b0;
            slv_age      <= 0;
        end
    end

    task automatic wb_access(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rdat, output logic ack,
                             output logic err, output int cs_cyc, output int lat);
        @(posedge mclk); #1;
        wbd.wbd_cyc_i = 1'b1; wbd.wbd_stb_i = 1'b1; wbd.wbd_we_i = we;
        wbd.wbd_adr_i = adr;  wbd.wbd_dat_i = dat;  wbd.wbd_sel_i = sel;
        ack = 1'b0; err = 1'b0; cs_cyc = 0; lat = 0;
        for (int i = 0; i < 40 && !ack && !err; i++) begin
            @(posedge mclk); #1;
            lat = i + 1;
            if (regb.reg_cs) cs_cyc++;
            ack = wbd.wbd_ack_o;
            err = wbd.wbd_err_o;
        end
        rdat = wbd.wbd_dat_o;
        wbd.wbd_cyc_i = 1'b0; wbd.wbd_stb_i = 1'b0; wbd.wbd_we_i = 1'b0;
        checks++;
        if (!(ack || err)) begin
            errors++;
            $display("FAIL access_bound adr=%h: no ack/err within 40 cycles", adr);
        end
    endtask

    task automatic test_reset();
        wbd.wbd_cyc_i = 0; wbd.wbd_stb_i = 0; wbd.wbd_we_i = 0;
        wbd.wbd_adr_i = '0; wbd.wbd_dat_i = '0; wbd.wbd_sel_i = '0;
        repeat (3) @(posedge mclk);
        #1;
        checks++;
        if ({regb.reg_cs, wbd.wbd_ack_o, wbd.wbd_err_o, timeout_flag} !== 4'b0000 || wbd.wbd_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: cs/ack/err/flag=%b dat_o=%h, want 0000 and 0",
                     {regb.reg_cs, wbd.wbd_ack_o, wbd.wbd_err_o, timeout_flag}, wbd.wbd_dat_o);
        end
        @(negedge mclk); h_reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic ack, err; int csc, lat;
        slv_delay = 1;
        wb_access(1'b1, 4'h0, 32'h0001_0203, 4'hF, rd, ack, err, csc, lat);
        checks++;
        if (csc !== 2 || lat !== 3 || ack !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL write_latency: cs_cycles=%0d lat=%0d ack=%b err=%b, want 2 3 1 0", csc, lat, ack, err);
        end
        wb_access(1'b0, 4'h0, 32'h0, 4'hF, rd, ack, err, csc, lat);
        checks++;
        if (rd !== 32'h0000_0203 || ack !== 1'b1) begin
            errors++;
            $display("FAIL write_readback: dat=%h ack=%b, want 00000203 1", rd, ack);
        end
        wb_access(1'b1, 4'(GLBL_INTR_MSK * 4), 32'h0000_002A, 4'hF, rd, ack, err, csc, lat);
        wb_access(1'b0, 4'(GLBL_INTR_MSK * 4), 32'h0, 4'hF, rd, ack, err, csc, lat);
        checks++;
        if (rd !== 32'h0000_002A || ack !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL read_0x08: dat=%h ack=%b err=%b, want 0000002a 1 0", rd, ack, err);
        end
        wb_access(1'b1, 4'hC, 32'hFFFF_5566, 4'b0001, rd, ack, err, csc, lat);
        wb_access(1'b0, 4'hC, 32'h0, 4'hF, rd, ack, err, csc, lat);
        checks++;
        if (rd !== 32'h0000_0066) begin
            errors++;
            $display("FAIL byte_enable: dat=%h, want 00000066", rd);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic ack, err; int csc, lat;
        slv_delay = 0;
        wb_access(1'b0, 4'hC, 32'h0, 4'hF, rd, ack, err, csc, lat);
        checks++;
        if (csc !== 15 || lat !== 16 || err !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cycles: cs_cycles=%0d lat=%0d err=%b ack=%b, want 15 16 1 0", csc, lat, err, ack);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF || timeout_flag !== 1'b1) begin
            errors++;
            $display("FAIL timeout_data: dat=%h flag=%b, want deadbeef 1", rd, timeout_flag);
        end
        @(posedge mclk); #1;
        checks++;
        if (wbd.wbd_err_o !== 1'b0 || regb.reg_cs !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: err=%b cs=%b one cycle later, want 0 0", wbd.wbd_err_o, regb.reg_cs);
        end
        slv_delay = 1;
        wb_access(1'b1, 4'h4, 32'h0000_1111, 4'hF, rd, ack, err, csc, lat);
        checks++;
        if (timeout_flag !== 1'b0 || ack !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL flag_clear: flag=%b ack=%b dat=%h, want 0 1 deadbeef", timeout_flag, ack, rd);
        end
    endtask

    task automatic test_ack_at_limit();
        logic [31:0] rd; logic ack, err; int csc, lat;
        slv_delay = 0;
        wb_access(1'b0, 4'h8, 32'h0, 4'hF, rd, ack, err, csc, lat);
        slv_delay = 14;
        wb_access(1'b0, 4'h8, 32'h0, 4'hF, rd, ack, err, csc, lat);
        checks++;
        if (ack !== 1'b1 || err !== 1'b0 || csc !== 15 || rd !== 32'h0000_002A || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL ack_priority: ack=%b err=%b cs_cycles=%0d dat=%h flag=%b, want 1 0 15 0000002a 0",
                     ack, err, csc, rd, timeout_flag);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic ack, err; int csc, lat; int acks0, ack_pulses, err_pulses;
        slv_delay = 1;
        acks0 = slv_acks; ack_pulses = 0; err_pulses = 0;
        @(posedge mclk); #1;
        wbd.wbd_cyc_i = 1; wbd.wbd_stb_i = 1; wbd.wbd_we_i = 1;
        wbd.wbd_adr_i = 4'h4; wbd.wbd_dat_i = 32'h0000_1234; wbd.wbd_sel_i = 4'hF;
        @(posedge mclk); #1;
        wbd.wbd_cyc_i = 0; wbd.wbd_stb_i = 0; wbd.wbd_we_i = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge mclk); #1;
            if (wbd.wbd_ack_o) ack_pulses++;
            if (wbd.wbd_err_o) err_pulses++;
        end
        checks++;
        if (ack_pulses !== 0 || err_pulses !== 0 || slv_acks - acks0 !== 1 || regb.reg_cs !== 1'b0) begin
            errors++;
            $display("FAIL abort_suppress: wb_acks=%0d wb_errs=%0d slave_acks=%0d cs=%b, want 0 0 1 0",
                     ack_pulses, err_pulses, slv_acks - acks0, regb.reg_cs);
        end
        wb_access(1'b0, 4'h4, 32'h0, 4'hF, rd, ack, err, csc, lat);
        checks++;
        if (rd !== 32'h0000_1234 || lat !== 3 || ack !== 1'b1) begin
            errors++;
            $display("FAIL abort_landed: dat=%h lat=%0d ack=%b, want 00001234 3 1", rd, lat, ack);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd; logic ack, err; int csc, lat; int pulses;
        slv_delay = 0; pulses = 0;
        @(posedge mclk); #1;
        wbd.wbd_cyc_i = 1; wbd.wbd_stb_i = 1; wbd.wbd_we_i = 0;
        wbd.wbd_adr_i = 4'h0; wbd.wbd_sel_i = 4'hF;
        repeat (3) @(posedge mclk);
        #2;
        checks++;
        if (regb.reg_cs !== 1'b1) begin
            errors++;
            $display("FAIL cs_before_reset: cs=%b, want 1", regb.reg_cs);
        end
        h_reset_n = 1'b0;
        #1;
        checks++;
        if (regb.reg_cs !== 1'b0 || wbd.wbd_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: cs=%b dat_o=%h within 1ns of reset, want 0 0", regb.reg_cs, wbd.wbd_dat_o);
        end
        wbd.wbd_cyc_i = 0; wbd.wbd_stb_i = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge mclk); #1;
            if (wbd.wbd_ack_o || wbd.wbd_err_o || regb.reg_cs) pulses++;
        end
        @(negedge mclk); h_reset_n = 1'b1;
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_quiet: %0d cycles with ack/err/cs during reset, want 0", pulses);
        end
        slv_delay = 1;
        wb_access(1'b0, 4'h0, 32'h0, 4'hF, rd, ack, err, csc, lat);
        checks++;
        if (ack !== 1'b1 || err !== 1'b0 || lat !== 3 || rd !== 32'h0000_0203) begin
            errors++;
            $display("FAIL after_reset: ack=%b err=%b lat=%0d dat=%h, want 1 0 3 00000203", ack, err, lat, rd);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_timeout();
        test_ack_at_limit();
        test_abort();
        test_async_reset();
        repeat (2) @(posedge mclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_reg_initiator.md
Name: pwm_reg_initiator

Overview:
Wishbone-classic slave to register-bus initiator bridge; drives the reg_cs/reg_wr/reg_addr/reg_wdata/reg_be request side and consumes reg_rdata/reg_ack from PWM-subsystem register blocks.
- Sits between the system wishbone interconnect and the PWM global/channel register slaves.
- Enforces the reg-bus hold-until-ack rule and drops cs immediately after ack, so a slave never sees a back-to-back re-ack.
- Adds a per-access timeout that returns a wishbone error.

Parameters:
- AW, 2, reg-bus address width; wbd_adr_i[AW+1:2] maps to reg_addr.
- TO_W, 4, timeout counter width.
- TIMEOUT, 15, cycles with reg_cs high and no reg_ack before abort; must be >=2 and <2^TO_W.
- ERR_DATA, 32'hDEAD_BEEF, value returned on wbd_dat_o for a timed-out read.

Ports:
- mclk  in  1  clock
- h_reset_n  in  1  reset; asynchronous, active-low
- wbd_cyc_i  in  1  wishbone cycle
- wbd_stb_i  in  1  wishbone strobe
- wbd_we_i  in  1  1=write
- wbd_adr_i  in  AW+2  byte address; bits [1:0] ignored
- wbd_dat_i  in  32  write data
- wbd_sel_i  in  4  byte selects
- wbd_dat_o  out  32  read data
- wbd_ack_o  out  1  access complete, 1-cycle pulse
- wbd_err_o  out  1  access timed out, 1-cycle pulse
- reg_cs  out  1  reg-bus chip select
- reg_wr  out  1  1=write
- reg_addr  out  AW  register index
- reg_wdata  out  32  write data
- reg_be  out  4  byte enables
- reg_rdata  in  32  slave read data, valid when reg_ack=1
- reg_ack  in  1  slave acknowledge
- timeout_flag  out  1  sticky; set on any timeout, cleared by the next successful access

Behaviour:
- Reset: every output is 0 (wbd_dat_o=0, timeout_flag=0); FSM=IDLE; timeout counter=0. An async reset mid-access aborts immediately: reg_cs drops with reset, and no ack or err is issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: when wbd_cyc_i & wbd_stb_i, capture we/adr/dat/sel into reg_wr/reg_addr/reg_wdata/reg_be, set reg_cs=1, clear the counter, go to ACCESS.
- ACCESS: reg_cs and all request fields are held stable. The counter increments each cycle.
  - On reg_ack=1: reg_cs<=0; wbd_dat_o<=reg_rdata for a read, unchanged for a write; wbd_ack_o<=1; timeout_flag<=0; go to RESP.
  - Else if counter==TIMEOUT-1: reg_cs<=0; wbd_err_o<=1; wbd_dat_o<=ERR_DATA for a read; timeout_flag<=1; go to RESP.
  - reg_ack takes priority over timeout in the same cycle.
- RESP: wbd_ack_o and wbd_err_o clear next cycle; go to IDLE. A strobe seen in RESP is ignored, so the minimum gap between accesses is 1 cycle.
- Latency with a 1-cycle slave: stb sampled at edge 0; reg_cs=1 in cycle 1; reg_ack=1 in cycle 2; wbd_ack_o=1 and reg_cs=0 in cycle 3. Total 3 cycles.
- Abort: if wbd_cyc_i drops while in ACCESS, the reg-bus access still completes or times out (no half-written register). The ack/err pulse is suppressed; state still passes through RESP.
- reg_ack arriving in IDLE or RESP is ignored. reg_ack arriving in ACCESS while reg_cs=1 is accepted. reg_cs is never asserted two cycles after ack.
- reg_wr/addr/wdata/be retain their last values when reg_cs=0; slaves ignore them.

Decomposition:
- Package pwm_reg_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the defaults for ERR_DATA and TIMEOUT;
  - the global-register address constants (GLBL_CTRL=0, GLBL_RSVD=1, GLBL_INTR_MSK=2, GLBL_INTR_STAT=3) for benches and firmware models.
- No sub-module; the timeout counter is inline.

Test Plan:
- Write adr=0x00, dat=0x0001_0203, sel=4'hF, 1-cycle slave -> reg_cs high exactly 2 cycles; wbd_ack_o in cycle 3; readback = 0x0001_0203 masked by the slave's implemented bits.
- Read adr=0x08 with slave reg_rdata=0x0000_002A -> wbd_dat_o=0x0000_002A with wbd_ack_o; wbd_err_o=0.
- Slave never acks -> reg_cs high exactly 15 cycles; wbd_err_o pulse; wbd_dat_o=0xDEAD_BEEF; timeout_flag=1; the next good access clears timeout_flag.
- reg_ack asserted in the same cycle the counter reaches 14 -> wbd_ack_o=1, wbd_err_o=0.
- wbd_cyc_i dropped in the cycle after a write request -> slave still sees one ack and the write lands; no wbd_ack_o; the FSM returns to IDLE.
- h_reset_n pulsed low while reg_cs=1 -> reg_cs=0 asynchronously; no ack or err; a following access completes normally.
